// File: rtl/uart_serial_port.sv
// uart_serial_port: 8N1 UART endpoint (LSB first) for the serial MMIO port.
// The TX path has a one-byte holding register in front of a shift FSM. Back-to-back
// bytes leave the line with no idle gap between frames.
// The RX path runs the line through a 2-flop synchronizer and a mid-bit sampling FSM.
// Received bytes go into a small FIFO. Its head is presented combinationally to the
// memory-mapped serial buffer.
module uart_serial_port #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  output logic       tx_ready_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rx_rden_in,
  input  logic       uart_rxd_in,
  output logic       uart_txd_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(RX_FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  // Bit-period counters count down. An event fires when a counter reads zero.
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(RX_FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // ---------------- TX ----------------
  tx_state_t        tx_state_reg, tx_state_next;
  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]       tx_bit_reg, tx_bit_next;
  logic [7:0]       tx_shift_reg, tx_shift_next;
  logic             txd_reg, txd_next;
  logic             hold_full_reg, hold_full_next;
  logic [7:0]       hold_data_reg, hold_data_next;
  logic             tx_load;

  // TX state, shifter, line and holding register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_reg  <= TX_IDLE;
      tx_cnt_reg    <= '0;
      tx_bit_reg    <= '0;
      tx_shift_reg  <= '0;
      txd_reg       <= 1'b1;
      hold_full_reg <= 1'b0;
      hold_data_reg <= '0;
    end else begin
      tx_state_reg  <= tx_state_next;
      tx_cnt_reg    <= tx_cnt_next;
      tx_bit_reg    <= tx_bit_next;
      tx_shift_reg  <= tx_shift_next;
      txd_reg       <= txd_next;
      hold_full_reg <= hold_full_next;
      hold_data_reg <= hold_data_next;
    end
  end

  // TX next-state: walk the frame, and reload from the holding register when it is full
  always_comb begin
    tx_state_next  = tx_state_reg;
    tx_cnt_next    = tx_cnt_reg;
    tx_bit_next    = tx_bit_reg;
    tx_shift_next  = tx_shift_reg;
    txd_next       = txd_reg;
    hold_full_next = hold_full_reg;
    hold_data_next = hold_data_reg;
    tx_load        = 1'b0;

    case (tx_state_reg)
      TX_IDLE: begin
        txd_next = 1'b1;
        if (hold_full_reg) tx_load = 1'b1;
      end
      TX_START: begin
        if (tx_cnt_reg == '0) begin
          tx_state_next = TX_DATA;
          txd_next      = tx_shift_reg[0];
          tx_bit_next   = '0;
          tx_cnt_next   = BIT_LAST;
        end else begin
          tx_cnt_next = tx_cnt_reg - CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_reg == '0) begin
          tx_cnt_next = BIT_LAST;
          if (tx_bit_reg == 3'd7) begin
            tx_state_next = TX_STOP;
            txd_next      = 1'b1;
          end else begin
            tx_shift_next = {1'b0, tx_shift_reg[7:1]};
            txd_next      = tx_shift_reg[1];
            tx_bit_next   = tx_bit_reg + 3'd1;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg - CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_reg == '0) begin
          // A byte that is already waiting starts right away, so there is no idle gap
          if (hold_full_reg) tx_load = 1'b1;
          else               tx_state_next = TX_IDLE;
        end else begin
          tx_cnt_next = tx_cnt_reg - CNT_W'(1);
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase

    if (tx_load) begin
      tx_state_next  = TX_START;
      tx_shift_next  = hold_data_reg;
      hold_full_next = 1'b0;
      txd_next       = 1'b0;
      tx_cnt_next    = BIT_LAST;
    end

    // A load needs hold_full=1 and an accepted write needs hold_full=0, so the two never collide
    if (tx_wren_in && !hold_full_reg) begin
      hold_full_next = 1'b1;
      hold_data_next = tx_data_in;
    end
  end

  assign tx_ready_out = ~hold_full_reg;
  assign uart_txd_out = txd_reg;

  // ---------------- RX ----------------
  logic [1:0]       sync_reg;
  logic             rxd_s;
  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]       rx_bit_reg, rx_bit_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic             push_req;
  logic             frame_err_reg, frame_err_next;
  logic             overrun_reg, overrun_next;

  // Two-flop synchronizer for the asynchronous line. It resets to idle (high).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_reg <= 2'b11;
    else        sync_reg <= {sync_reg[0], uart_rxd_in};
  end
  assign rxd_s = sync_reg[1];

  // RX state, sample counter, shifter and registered error pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_reg  <= RX_IDLE;
      rx_cnt_reg    <= '0;
      rx_bit_reg    <= '0;
      rx_shift_reg  <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      rx_state_reg  <= rx_state_next;
      rx_cnt_reg    <= rx_cnt_next;
      rx_bit_reg    <= rx_bit_next;
      rx_shift_reg  <= rx_shift_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  // RX next-state: sample each bit at its middle, check the stop bit, and ride out a break
  always_comb begin
    rx_state_next  = rx_state_reg;
    rx_cnt_next    = rx_cnt_reg;
    rx_bit_next    = rx_bit_reg;
    rx_shift_next  = rx_shift_reg;
    push_req       = 1'b0;
    frame_err_next = 1'b0;

    case (rx_state_reg)
      RX_IDLE: begin
        if (!rxd_s) begin
          rx_state_next = RX_START;
          rx_cnt_next   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt_reg == '0) begin
          rx_cnt_next = BIT_LAST;
          rx_bit_next = '0;
          rx_state_next = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == '0) begin
          rx_shift_next = {rxd_s, rx_shift_reg[7:1]};
          rx_cnt_next   = BIT_LAST;
          if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
          else                    rx_bit_next   = rx_bit_reg + 3'd1;
        end else begin
          rx_cnt_next = rx_cnt_reg - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_reg == '0) begin
          if (rxd_s) begin
            push_req      = 1'b1;
            rx_state_next = RX_IDLE;
          end else begin
            frame_err_next = 1'b1;
            rx_state_next  = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg - CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rxd_s) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]        fifo_mem [RX_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [FCNT_W-1:0] fifo_cnt_reg;
  logic              fifo_pop, fifo_push;

  // A pop makes room in the same cycle, so a full FIFO still accepts a push that coincides with a pop
  always_comb begin
    fifo_pop     = rx_rden_in && (fifo_cnt_reg != '0);
    fifo_push    = push_req && ((fifo_cnt_reg != FIFO_FULL) || fifo_pop);
    overrun_next = push_req && !fifo_push;
  end

  // FIFO storage. It has no reset and is only ever read below the count.
  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem[wr_ptr_reg] <= rx_shift_reg;
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + FCNT_W'(1);
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - FCNT_W'(1);
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  assign rx_valid_out     = (fifo_cnt_reg != '0);
  assign rx_data_out      = rx_valid_out ? fifo_mem[rd_ptr_reg] : 8'h00;
  assign rx_overrun_out   = overrun_reg;
  assign rx_frame_err_out = frame_err_reg;

endmodule

// File: tb/tb_uart_serial_port.sv
// tb_uart_serial_port: randomized self-checking bench for uart_serial_port (8 clocks/bit, 4-entry FIFO).
// The expected TX line is built from the frame definition: a start bit, 8 data bits LSB first,
// then a stop bit. Expected RX contents come from a byte queue that models the FIFO.
module tb_uart_serial_port;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_wren_in = 1'b0;
  logic       tx_ready_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       rx_rden_in = 1'b0;
  logic       uart_rxd_in = 1'b1;
  logic       uart_txd_out;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;

  int checks = 0;
  int errors = 0;
  int overrun_cnt = 0;
  int frame_err_cnt = 0;
  logic [7:0] rx_model [$];

  uart_serial_port #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .tx_data_in(tx_data_in), .tx_wren_in(tx_wren_in), .tx_ready_out(tx_ready_out),
    .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out), .rx_rden_in(rx_rden_in),
    .uart_rxd_in(uart_rxd_in), .uart_txd_out(uart_txd_out),
    .rx_overrun_out(rx_overrun_out), .rx_frame_err_out(rx_frame_err_out)
  );

  always #5 clock = ~clock;

  // Count error pulses, one count per cycle that a pulse is high
  always @(negedge clock) begin
    if (rx_overrun_out)   overrun_cnt++;
    if (rx_frame_err_out) frame_err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame bit j of an 8N1 frame carrying byte b (0 = start, 1..8 = data LSB first, 9 = stop)
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive one frame on the RX line. extra_low keeps the line low after the stop cell.
  // If pop_at >= 0, the FIFO head is captured in that cycle and a one-cycle pop is issued.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra_low,
                            input int pop_at, output logic popped_valid, output logic [7:0] popped_data);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    popped_valid = 1'b0;
    popped_data  = 8'h00;
    for (int c = 0; c < 10*CPB + extra_low; c++) begin
      @(negedge clock);
      uart_rxd_in = (c < 10*CPB) ? bits[c/CPB] : 1'b0;
      if (c == pop_at) begin
        popped_valid = rx_valid_out;
        popped_data  = rx_data_out;
        rx_rden_in   = 1'b1;
      end else begin
        rx_rden_in = 1'b0;
      end
    end
    @(negedge clock);
    uart_rxd_in = 1'b1;
    rx_rden_in  = 1'b0;
  endtask

  task automatic test_reset();
    logic       pv;
    logic [7:0] pd;
    int         bad;
    idle(3);
    checks++;
    if (uart_txd_out !== 1'b1 || tx_ready_out !== 1'b1 || rx_valid_out !== 1'b0 ||
        rx_data_out !== 8'h00 || rx_overrun_out !== 1'b0 || rx_frame_err_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: txd=%b ready=%b valid=%b data=%h ovr=%b ferr=%b, expected 1 1 0 00 0 0",
               uart_txd_out, tx_ready_out, rx_valid_out, rx_data_out, rx_overrun_out, rx_frame_err_out);
    end
    @(negedge clock) reset = 1'b1;
    idle(2);
    // Put a byte in the FIFO so the reset can be seen to empty it
    send_frame(8'($urandom), 1'b1, 0, -1, pv, pd);
    checks++;
    if (rx_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill: valid=%b, expected 1", rx_valid_out);
    end
    @(negedge clock); tx_data_in = 8'h55; tx_wren_in = 1'b1;
    @(negedge clock); tx_wren_in = 1'b0;
    idle(20);  // inside data bit 1 of 0x55, which is a 0
    checks++;
    if (uart_txd_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe_txd: txd=%b, expected 0", uart_txd_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (uart_txd_out !== 1'b1 || tx_ready_out !== 1'b1 || rx_valid_out !== 1'b0 || rx_data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: txd=%b ready=%b valid=%b data=%h, expected 1 1 0 00",
               uart_txd_out, tx_ready_out, rx_valid_out, rx_data_out);
    end
    @(negedge clock) reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (uart_txd_out !== 1'b1 || tx_ready_out !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_release_idle: %0d non-idle cycles, expected 0", bad);
    end
    $display("reset test: done");
  endtask

  task automatic test_tx_single(input logic [7:0] d);
    logic exp;
    @(negedge clock); tx_data_in = d; tx_wren_in = 1'b1;
    @(negedge clock); tx_wren_in = 1'b0;
    checks++;
    if (tx_ready_out !== 1'b0 || uart_txd_out !== 1'b1) begin
      errors++;
      $display("FAIL tx_accept: ready=%b txd=%b, expected 0 1", tx_ready_out, uart_txd_out);
    end
    for (int i = 0; i < 10*CPB; i++) begin
      @(negedge clock);
      exp = frame_bit(d, i / CPB);
      checks++;
      if (uart_txd_out !== exp) begin
        errors++;
        $display("FAIL tx_bit: byte %h cycle %0d txd=%b, expected %b", d, i, uart_txd_out, exp);
      end
      if (i == 0) begin
        checks++;
        if (tx_ready_out !== 1'b1) begin
          errors++;
          $display("FAIL tx_ready_rise: ready=%b, expected 1", tx_ready_out);
        end
      end
    end
    @(negedge clock);
    checks++;
    if (uart_txd_out !== 1'b1 || tx_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL tx_after_frame: txd=%b ready=%b, expected 1 1", uart_txd_out, tx_ready_out);
    end
    $display("tx single: byte %h sent", d);
  endtask

  task automatic test_back_to_back();
    logic exp, exp_ready;
    @(negedge clock); tx_data_in = 8'h00; tx_wren_in = 1'b1;
    @(negedge clock); tx_wren_in = 1'b0;
    checks++;
    if (tx_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: ready=%b, expected 0", tx_ready_out);
    end
    for (int i = 0; i < 20*CPB + 20; i++) begin
      @(negedge clock);
      if (i < 10*CPB)      exp = frame_bit(8'h00, i / CPB);
      else if (i < 20*CPB) exp = frame_bit(8'hFF, (i - 10*CPB) / CPB);
      else                 exp = 1'b1;
      exp_ready = (i == 0) || (i >= 10*CPB);
      checks++;
      if (uart_txd_out !== exp || tx_ready_out !== exp_ready) begin
        errors++;
        $display("FAIL b2b_cycle: cycle %0d txd=%b ready=%b, expected %b %b",
                 i, uart_txd_out, tx_ready_out, exp, exp_ready);
      end
      if (i == 0)      begin tx_data_in = 8'hFF; tx_wren_in = 1'b1; end
      else if (i == 1) begin tx_data_in = 8'hAA; tx_wren_in = 1'b1; end  // not ready: dropped
      else             tx_wren_in = 1'b0;
    end
    $display("tx back-to-back: 00 then FF sent, AA dropped");
  endtask

  task automatic test_rx_single();
    logic       pv;
    logic [7:0] pd;
    logic [7:0] b;
    int         ov0, fe0;
    ov0 = overrun_cnt;
    fe0 = frame_err_cnt;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? 8'h3C : 8'($urandom);
      send_frame(b, 1'b1, 0, -1, pv, pd);
      checks++;
      if (rx_valid_out !== 1'b1 || rx_data_out !== b) begin
        errors++;
        $display("FAIL rx_single_recv: valid=%b data=%h, expected 1 %h", rx_valid_out, rx_data_out, b);
      end
      @(negedge clock) rx_rden_in = 1'b1;
      @(negedge clock) rx_rden_in = 1'b0;
      checks++;
      if (rx_valid_out !== 1'b0 || rx_data_out !== 8'h00) begin
        errors++;
        $display("FAIL rx_single_pop: valid=%b data=%h, expected 0 00", rx_valid_out, rx_data_out);
      end
      $display("rx single: byte %h received and popped", b);
    end
    checks++;
    if (overrun_cnt != ov0 || frame_err_cnt != fe0) begin
      errors++;
      $display("FAIL rx_single_pulses: overrun %0d frame_err %0d, expected 0 0",
               overrun_cnt - ov0, frame_err_cnt - fe0);
    end
  endtask

  task automatic test_rx_overrun_wrap();
    logic       pv;
    logic [7:0] pd;
    logic [7:0] b;
    int         ov0, exp_ov, pop_at;
    ov0 = overrun_cnt;
    exp_ov = 0;
    rx_model.delete();
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1, 0, -1, pv, pd);
      if (rx_model.size() < DEPTH) rx_model.push_back(8'(v));
      else                         exp_ov++;
      checks++;
      if (overrun_cnt - ov0 != exp_ov || rx_data_out !== rx_model[0]) begin
        errors++;
        $display("FAIL rx_fill: frame %0d overruns=%0d head=%h, expected %0d %h",
                 v, overrun_cnt - ov0, rx_data_out, exp_ov, rx_model[0]);
      end
      $display("rx fill: frame %0d sent, overruns %0d", v, overrun_cnt - ov0);
    end
    while (rx_model.size() > 0) begin
      @(negedge clock);
      checks++;
      if (rx_valid_out !== 1'b1 || rx_data_out !== rx_model[0]) begin
        errors++;
        $display("FAIL rx_drain: valid=%b data=%h, expected 1 %h", rx_valid_out, rx_data_out, rx_model[0]);
      end
      void'(rx_model.pop_front());
      rx_rden_in = 1'b1;
      @(negedge clock) rx_rden_in = 1'b0;
    end
    checks++;
    if (rx_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rx_drained_empty: valid=%b, expected 0", rx_valid_out);
    end
    // Second pass wraps the pointers. Frame 4 pops at the exact push cycle with the FIFO full;
    // frame 5 pops mid-frame.
    for (int j = 0; j < 6; j++) begin
      b = 8'($urandom);
      pop_at = (j == 4) ? (9*CPB + CPB/2 + 2) : (j == 5) ? 20 : -1;
      send_frame(b, 1'b1, 0, pop_at, pv, pd);
      if (pop_at >= 0) begin
        checks++;
        if (pv !== 1'b1 || pd !== rx_model[0]) begin
          errors++;
          $display("FAIL rx_wrap_pop: frame %0d valid=%b data=%h, expected 1 %h", j, pv, pd, rx_model[0]);
        end
        void'(rx_model.pop_front());
      end
      rx_model.push_back(b);
      checks++;
      if (overrun_cnt - ov0 != 1 || rx_data_out !== rx_model[0]) begin
        errors++;
        $display("FAIL rx_wrap_push: frame %0d overruns=%0d head=%h, expected 1 %h",
                 j, overrun_cnt - ov0, rx_data_out, rx_model[0]);
      end
      $display("rx wrap: frame %0d byte %h sent", j, b);
    end
    while (rx_model.size() > 0) begin
      @(negedge clock);
      checks++;
      if (rx_valid_out !== 1'b1 || rx_data_out !== rx_model[0]) begin
        errors++;
        $display("FAIL rx_wrap_drain: valid=%b data=%h, expected 1 %h", rx_valid_out, rx_data_out, rx_model[0]);
      end
      void'(rx_model.pop_front());
      rx_rden_in = 1'b1;
      @(negedge clock) rx_rden_in = 1'b0;
    end
    checks++;
    if (rx_valid_out !== 1'b0 || rx_data_out !== 8'h00) begin
      errors++;
      $display("FAIL rx_wrap_empty: valid=%b data=%h, expected 0 00", rx_valid_out, rx_data_out);
    end
  endtask

  task automatic test_rx_errors();
    logic       pv;
    logic [7:0] pd;
    int         fe0, ov0;
    fe0 = frame_err_cnt;
    ov0 = overrun_cnt;
    @(negedge clock) uart_rxd_in = 1'b0;
    @(negedge clock);
    @(negedge clock) uart_rxd_in = 1'b1;
    idle(100);
    checks++;
    if (rx_valid_out !== 1'b0 || frame_err_cnt != fe0) begin
      errors++;
      $display("FAIL rx_glitch: valid=%b frame_err=%0d, expected 0 0", rx_valid_out, frame_err_cnt - fe0);
    end
    $display("rx errors: glitch rejected");
    send_frame(8'($urandom), 1'b0, 0, -1, pv, pd);
    idle(4);
    checks++;
    if (rx_valid_out !== 1'b0 || frame_err_cnt - fe0 != 1) begin
      errors++;
      $display("FAIL rx_bad_stop: valid=%b frame_err=%0d, expected 0 1", rx_valid_out, frame_err_cnt - fe0);
    end
    $display("rx errors: bad stop bit flagged");
    send_frame(8'($urandom), 1'b0, 30, -1, pv, pd);
    idle(10);
    checks++;
    if (rx_valid_out !== 1'b0 || frame_err_cnt - fe0 != 2) begin
      errors++;
      $display("FAIL rx_break: valid=%b frame_err=%0d, expected 0 2", rx_valid_out, frame_err_cnt - fe0);
    end
    send_frame(8'h7E, 1'b1, 0, -1, pv, pd);
    idle(2);
    checks++;
    if (rx_valid_out !== 1'b1 || rx_data_out !== 8'h7E) begin
      errors++;
      $display("FAIL rx_after_break: valid=%b data=%h, expected 1 7e", rx_valid_out, rx_data_out);
    end
    @(negedge clock) rx_rden_in = 1'b1;
    @(negedge clock) rx_rden_in = 1'b0;
    checks++;
    if (rx_valid_out !== 1'b0 || overrun_cnt != ov0 || frame_err_cnt - fe0 != 2) begin
      errors++;
      $display("FAIL rx_only_one: valid=%b overrun=%0d frame_err=%0d, expected 0 0 2",
               rx_valid_out, overrun_cnt - ov0, frame_err_cnt - fe0);
    end
    $display("rx errors: break then 7e received alone");
  endtask

  initial begin
    test_reset();
    test_tx_single(8'hA5);
    test_tx_single(8'($urandom));
    test_back_to_back();
    test_rx_single();
    test_rx_overrun_wrap();
    test_rx_errors();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
